// File: rtl/wav_stream_parser.sv
// wav_stream_parser: checks a canonical 44-byte PCM WAV header arriving as a
// byte stream, exposes the decoded format fields, then forwards exactly
// data_size payload bytes as 8-bit samples over a valid/ready interface.
module wav_stream_parser #(
  parameter bit STRICT = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        restart_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        sample_valid_o,
  output logic [7:0]  sample_data_o,
  input  logic        sample_ready_i,
  output logic [31:0] sample_rate_o,
  output logic [15:0] num_channels_o,
  output logic [15:0] bits_per_sample_o,
  output logic [31:0] data_size_o,
  output logic        hdr_done_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned IDX_W         = 6;
  localparam int unsigned LAST_HDR_BYTE = 43;

  // Magic words as they appear once four file-order bytes are packed little-endian
  localparam logic [31:0] MAGIC_RIFF = 32'h4646_4952;
  localparam logic [31:0] MAGIC_WAVE = 32'h4556_4157;
  localparam logic [31:0] MAGIC_FMT  = 32'h2074_6D66;
  localparam logic [31:0] MAGIC_DATA = 32'h6174_6164;

  typedef enum logic [2:0] {
    S_HEADER,
    S_DATA,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [23:0]      shift_q;      // previous three header bytes, newest in [23:16]
  logic [31:0]      remaining_q;

  logic        byte_fire;
  logic        sample_fire;
  logic [31:0] word_c;            // 4-byte field ending at the current byte
  logic [15:0] half_c;            // 2-byte field ending at the current byte
  logic        hdr_bad_c;

  assign byte_fire   = byte_valid_i & byte_ready_o;
  assign sample_fire = sample_valid_o & sample_ready_i;
  assign word_c      = {byte_data_i, shift_q};
  assign half_c      = {byte_data_i, shift_q[23:16]};

  // Input ready from state; a restart cycle never accepts a byte
  always_comb begin
    byte_ready_o = 1'b0;
    case (state_q)
      S_HEADER: byte_ready_o = ~restart_i;
      S_DATA:   byte_ready_o = ~restart_i & (~sample_valid_o | sample_ready_i);
      default:  byte_ready_o = 1'b0;
    endcase
  end

  // Header field check, evaluated on the last byte of each checked field
  always_comb begin
    hdr_bad_c = 1'b0;
    case (idx_q)
      6'd3:    hdr_bad_c = (word_c != MAGIC_RIFF);
      6'd11:   hdr_bad_c = (word_c != MAGIC_WAVE);
      6'd15:   hdr_bad_c = (word_c != MAGIC_FMT);
      6'd19:   hdr_bad_c = (word_c != 32'd16);
      6'd21:   hdr_bad_c = (half_c != 16'd1);
      6'd23:   hdr_bad_c = STRICT & (half_c != 16'd1);
      6'd33:   hdr_bad_c = STRICT & (half_c != 16'd1);
      6'd35:   hdr_bad_c = STRICT & (half_c != 16'd8);
      6'd39:   hdr_bad_c = (word_c != MAGIC_DATA);
      default: hdr_bad_c = 1'b0;
    endcase
  end

  // Parser state, field capture, payload register and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q           <= S_HEADER;
      idx_q             <= '0;
      shift_q           <= '0;
      remaining_q       <= '0;
      sample_valid_o    <= 1'b0;
      sample_data_o     <= '0;
      sample_rate_o     <= '0;
      num_channels_o    <= '0;
      bits_per_sample_o <= '0;
      data_size_o       <= '0;
      hdr_done_o        <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else if (restart_i) begin
      state_q           <= S_HEADER;
      idx_q             <= '0;
      shift_q           <= '0;
      remaining_q       <= '0;
      sample_valid_o    <= 1'b0;
      sample_data_o     <= '0;
      sample_rate_o     <= '0;
      num_channels_o    <= '0;
      bits_per_sample_o <= '0;
      data_size_o       <= '0;
      hdr_done_o        <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      case (state_q)
        S_HEADER: begin
          if (byte_fire) begin
            idx_q   <= idx_q + IDX_W'(1);
            shift_q <= {byte_data_i, shift_q[23:8]};
            case (idx_q)
              6'd22, 6'd23:
                num_channels_o[{idx_q[0], 3'b000} +: 8] <= byte_data_i;
              6'd24, 6'd25, 6'd26, 6'd27:
                sample_rate_o[{idx_q[1:0], 3'b000} +: 8] <= byte_data_i;
              6'd34, 6'd35:
                bits_per_sample_o[{idx_q[0], 3'b000} +: 8] <= byte_data_i;
              6'd40, 6'd41, 6'd42, 6'd43:
                data_size_o[{idx_q[1:0], 3'b000} +: 8] <= byte_data_i;
              default: ;
            endcase
            if (hdr_bad_c) begin
              state_q <= S_ERROR;
              error_o <= 1'b1;
            end else if (idx_q == IDX_W'(LAST_HDR_BYTE)) begin
              hdr_done_o  <= 1'b1;
              remaining_q <= word_c;
              state_q     <= (word_c == 32'd0) ? S_DRAIN : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_fire) begin
            sample_valid_o <= 1'b1;
            sample_data_o  <= byte_data_i;
            remaining_q    <= remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state_q <= S_DRAIN;
            end
          end else if (sample_fire) begin
            sample_valid_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (~sample_valid_o | sample_ready_i) begin
            sample_valid_o <= 1'b0;
            done_o         <= 1'b1;
            state_q        <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wav_stream_parser.sv
// Scoreboard bench for wav_stream_parser: stimulus pushes expected samples,
// a negedge monitor pops and compares on every sample handshake.
module tb_wav_stream_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        restart;
  logic        byte_valid, ns_byte_valid;
  logic [7:0]  byte_data, ns_byte_data;
  logic        byte_ready, ns_byte_ready;
  logic        sample_valid, ns_sample_valid;
  logic [7:0]  sample_data, ns_sample_data;
  logic        sample_ready;
  logic        ns_sample_ready = 1'b1;
  logic [31:0] rate, ns_rate;
  logic [15:0] nch, ns_nch;
  logic [15:0] bps, ns_bps;
  logic [31:0] dsize, ns_dsize;
  logic        hdr_done, ns_hdr_done;
  logic        done, ns_done;
  logic        err, ns_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
  bit any_valid = 0;
  bit ready_toggle = 0;
  logic ready_level = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] hdr[44];

  wav_stream_parser #(.STRICT(1'b1)) dut (
    .clk(clk), .rstn(rstn), .restart_i(restart),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .sample_valid_o(sample_valid), .sample_data_o(sample_data), .sample_ready_i(sample_ready),
    .sample_rate_o(rate), .num_channels_o(nch), .bits_per_sample_o(bps), .data_size_o(dsize),
    .hdr_done_o(hdr_done), .done_o(done), .error_o(err)
  );

  wav_stream_parser #(.STRICT(1'b0)) dut_ns (
    .clk(clk), .rstn(rstn), .restart_i(restart),
    .byte_valid_i(ns_byte_valid), .byte_data_i(ns_byte_data), .byte_ready_o(ns_byte_ready),
    .sample_valid_o(ns_sample_valid), .sample_data_o(ns_sample_data), .sample_ready_i(ns_sample_ready),
    .sample_rate_o(ns_rate), .num_channels_o(ns_nch), .bits_per_sample_o(ns_bps), .data_size_o(ns_dsize),
    .hdr_done_o(ns_hdr_done), .done_o(ns_done), .error_o(ns_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sink ready: either a fixed level or toggling every cycle
  always @(posedge clk) begin
    #1;
    if (ready_toggle) sample_ready = ~sample_ready;
    else              sample_ready = ready_level;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, ready-when-full
  bit prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rstn === 1'b1 && restart === 1'b0) begin
      if (prev_stall) begin
        check("stall_valid_hold", 32'(sample_valid), 32'd1);
        check("stall_data_hold", 32'(sample_data), 32'(prev_data));
      end
      if (sample_valid && !sample_ready) check("ready_low_when_full", 32'(byte_ready), 32'd0);
      if (sample_valid) any_valid = 1;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: actual 0x%0h with no sample required", sample_data);
        end else begin
          check("sample_data", 32'(sample_data), 32'(exp_q.pop_front()));
          pops++;
          if (pops == 1) first_pop = cyc;
          last_pop = cyc;
        end
      end
      prev_stall = sample_valid && !sample_ready;
      prev_data  = sample_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic build_hdr(input logic [15:0] ch, input logic [31:0] rate_v, input logic [15:0] bits,
                           input logic [15:0] balign, input logic [31:0] ds, input logic [7:0] byte8);
    logic [31:0] riff_sz, brate, fmt_sz;
    logic [15:0] pcm;
    riff_sz = 32'd36 + ds;
    brate   = rate_v * 32'(balign);
    fmt_sz  = 32'd16;
    pcm     = 16'd1;
    hdr[0] = "R"; hdr[1] = "I"; hdr[2] = "F"; hdr[3] = "F";
    hdr[8] = byte8; hdr[9] = "A"; hdr[10] = "V"; hdr[11] = "E";
    hdr[12] = "f"; hdr[13] = "m"; hdr[14] = "t"; hdr[15] = " ";
    hdr[36] = "d"; hdr[37] = "a"; hdr[38] = "t"; hdr[39] = "a";
    for (int k = 0; k < 4; k++) begin
      hdr[4+k]  = riff_sz[8*k +: 8];
      hdr[16+k] = fmt_sz[8*k +: 8];
      hdr[24+k] = rate_v[8*k +: 8];
      hdr[28+k] = brate[8*k +: 8];
      hdr[40+k] = ds[8*k +: 8];
    end
    for (int k = 0; k < 2; k++) begin
      hdr[20+k] = pcm[8*k +: 8];
      hdr[22+k] = ch[8*k +: 8];
      hdr[32+k] = balign[8*k +: 8];
      hdr[34+k] = bits[8*k +: 8];
    end
  endtask

  // Present one byte and hold it until accepted (bounded)
  task automatic send_byte(input bit to_ns, input logic [7:0] b);
    bit acc = 0;
    if (to_ns) begin ns_byte_data = b; ns_byte_valid = 1'b1; end
    else       begin byte_data = b;    byte_valid = 1'b1;    end
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = to_ns ? ns_byte_ready : byte_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte 0x%0h never accepted, required acceptance", b);
    end
  endtask

  task automatic send_header(input bit to_ns, input int n);
    for (int i = 0; i < n; i++) send_byte(to_ns, hdr[i]);
  endtask

  task automatic idle();
    byte_valid = 1'b0;
    ns_byte_valid = 1'b0;
  endtask

  task automatic send_payload(input bit to_ns);
    for (int i = 0; i < pay.size(); i++) begin
      if (!to_ns) exp_q.push_back(pay[i]);
      send_byte(to_ns, pay[i]);
      if (to_ns) begin
        check("ns_sample_valid", 32'(ns_sample_valid), 32'd1);
        check("ns_sample_data", 32'(ns_sample_data), 32'(pay[i]));
      end
    end
    idle();
  endtask

  task automatic wait_done(input bit to_ns, input string name);
    for (int t = 0; t < 32; t++) begin
      if ((to_ns ? ns_done : done) === 1'b1) break;
      @(posedge clk);
      #1;
    end
    check(name, 32'(to_ns ? ns_done : done), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    restart = 1'b0;
    pops = 0;
    any_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; restart = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    ns_byte_valid = 1'b0; ns_byte_data = 8'h00;
    sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_data", 32'(sample_data), 32'd0);
    check("rst_rate", rate, 32'd0);
    check("rst_nch", 32'(nch), 32'd0);
    check("rst_bps", 32'(bps), 32'd0);
    check("rst_dsize", dsize, 32'd0);
    check("rst_hdr_done", 32'(hdr_done), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(err), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Valid 8-bit mono 48 kHz, 4 samples, sink always ready
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd4, "W");
    send_header(0, 44);
    idle();
    check("t1_hdr_done", 32'(hdr_done), 32'd1);
    check("t1_error", 32'(err), 32'd0);
    check("t1_rate", rate, 32'd48000);
    check("t1_nch", 32'(nch), 32'd1);
    check("t1_bps", 32'(bps), 32'd8);
    check("t1_dsize", dsize, 32'd4);
    pay = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pay[i]);
      send_byte(0, pay[i]);
    end
    byte_data = 8'h55;
    byte_valid = 1'b1;
    @(negedge clk);
    check("t1_done_before_last", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_trailing_ready", 32'(byte_ready), 32'd0);
    check("t1_valid_in_done", 32'(sample_valid), 32'd0);
    idle();
    check("t1_pops", 32'(pops), 32'd4);
    check("t1_consecutive", 32'(last_pop - first_pop), 32'd3);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same file with sink ready toggling
    do_restart();
    ready_toggle = 1;
    send_header(0, 44);
    idle();
    check("t2_hdr_done", 32'(hdr_done), 32'd1);
    send_payload(0);
    wait_done(0, "t2_done");
    check("t2_pops", 32'(pops), 32'd4);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    ready_toggle = 0;
    ready_level = 1'b1;

    // Corrupted WAVE magic, then restart with a good file
    do_restart();
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd2, "X");
    send_header(0, 11);
    check("t3_no_error_yet", 32'(err), 32'd0);
    send_byte(0, hdr[11]);
    byte_data = hdr[12];
    check("t3_error", 32'(err), 32'd1);
    check("t3_hdr_done", 32'(hdr_done), 32'd0);
    check("t3_ready_low", 32'(byte_ready), 32'd0);
    idle();
    do_restart();
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd2, "W");
    send_header(0, 44);
    idle();
    check("t3_restart_hdr_done", 32'(hdr_done), 32'd1);
    check("t3_restart_error", 32'(err), 32'd0);
    pay = '{8'h11, 8'h22};
    send_payload(0);
    wait_done(0, "t3_done");

    // Stereo 16-bit: rejected when strict, accepted when relaxed
    do_restart();
    build_hdr(16'd2, 32'd48000, 16'd16, 16'd2, 32'd2, "W");
    send_header(0, 23);
    check("t4_no_error_yet", 32'(err), 32'd0);
    send_byte(0, hdr[23]);
    idle();
    check("t4_strict_error", 32'(err), 32'd1);
    check("t4_strict_nch", 32'(nch), 32'd2);
    send_header(1, 44);
    idle();
    check("t4_ns_hdr_done", 32'(ns_hdr_done), 32'd1);
    check("t4_ns_error", 32'(ns_err), 32'd0);
    check("t4_ns_bps", 32'(ns_bps), 32'd16);
    check("t4_ns_nch", 32'(ns_nch), 32'd2);
    pay = '{8'hA5, 8'h5A};
    send_payload(1);
    wait_done(1, "t4_ns_done");

    // Empty data chunk
    do_restart();
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd0, "W");
    send_header(0, 44);
    idle();
    check("t5_hdr_done", 32'(hdr_done), 32'd1);
    check("t5_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("t5_done", 32'(done), 32'd1);
    check("t5_no_sample", 32'(any_valid), 32'd0);
    check("t5_ready_low", 32'(byte_ready), 32'd0);

    // Restart with a stalled pending sample
    ready_level = 1'b0;
    do_restart();
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd4, "W");
    send_header(0, 44);
    idle();
    pay = '{8'h80};
    send_payload(0);
    check("t6_stalled_valid", 32'(sample_valid), 32'd1);
    byte_data = 8'hFF;
    byte_valid = 1'b1;
    restart = 1'b1;
    @(negedge clk);
    check("t6_ready_in_restart", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    restart = 1'b0;
    idle();
    exp_q.delete();
    pops = 0;
    check("t6_valid_dropped", 32'(sample_valid), 32'd0);
    check("t6_data_cleared", 32'(sample_data), 32'd0);
    check("t6_rate_cleared", rate, 32'd0);
    check("t6_nch_cleared", 32'(nch), 32'd0);
    check("t6_bps_cleared", 32'(bps), 32'd0);
    check("t6_dsize_cleared", dsize, 32'd0);
    check("t6_hdr_done_cleared", 32'(hdr_done), 32'd0);
    ready_level = 1'b1;
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd1, "W");
    send_header(0, 44);
    idle();
    check("t6_reparse_hdr_done", 32'(hdr_done), 32'd1);
    check("t6_reparse_error", 32'(err), 32'd0);
    pay = '{8'h3C};
    send_payload(0);
    wait_done(0, "t6_done");

    // Asynchronous reset mid-header
    do_restart();
    build_hdr(16'd1, 32'd48000, 16'd8, 16'd1, 32'd4, "W");
    send_header(0, 30);
    check("t7_rate_partial", rate, 32'd48000);
    #2;
    rstn = 1'b0;
    #1;
    check("t7_rst_ready", 32'(byte_ready), 32'd1);
    check("t7_rst_rate", rate, 32'd0);
    check("t7_rst_nch", 32'(nch), 32'd0);
    check("t7_rst_valid", 32'(sample_valid), 32'd0);
    check("t7_rst_hdr_done", 32'(hdr_done), 32'd0);
    check("t7_rst_error", 32'(err), 32'd0);
    idle();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    pops = 0;
    exp_q.delete();
    send_header(0, 44);
    idle();
    check("t7_hdr_done", 32'(hdr_done), 32'd1);
    check("t7_rate", rate, 32'd48000);
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_payload(0);
    wait_done(0, "t7_done");
    check("t7_pops", 32'(pops), 32'd4);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wav_stream_parser.md
# wav_stream_parser

Byte-stream reader for canonical 44-byte-header PCM WAV files: the reverse of the sample-capture path that packs 8-bit mono 48 kHz audio into `.wav` files. Parses and checks the RIFF/WAVE/fmt/data header, exposes the decoded format fields, then forwards exactly `data_size` payload bytes as 8-bit unsigned samples over a valid/ready interface. Sits between a byte source (file loader, UART, SPI flash reader) and the audio sample sink (mixer/DAC driver).

## Interface

- `STRICT`, default 1: 1 = reject any header that is not mono, 8-bit or 1-byte block align; 0 = only check magic words, fmt size and audio format.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `restart_i`  in  1  synchronous restart to header parsing; clears all captured fields and flags.
- `byte_valid_i`  in  1  input byte valid.
- `byte_data_i`  in  8  input byte, file order.
- `byte_ready_o`  out  1  input byte accepted when `byte_valid_i & byte_ready_o`.
- `sample_valid_o`  out  1  output sample valid.
- `sample_data_o`  out  8  unsigned PCM sample, passed through unchanged.
- `sample_ready_i`  in  1  sink accepts sample.
- `sample_rate_o`  out  32  header bytes 24-27, little-endian.
- `num_channels_o`  out  16  header bytes 22-23.
- `bits_per_sample_o`  out  16  header bytes 34-35.
- `data_size_o`  out  32  header bytes 40-43.
- `hdr_done_o`  out  1  header parsed and valid; held until restart/reset.
- `done_o`  out  1  all payload bytes forwarded and last sample accepted.
- `error_o`  out  1  header check failed; held until restart/reset.

## Operation

- FSM states: HEADER, DATA, DRAIN, DONE, ERROR. Reset/restart -> HEADER.
- HEADER: `byte_ready_o`=1. 6-bit byte index 0..43, increments per accepted byte. Multi-byte fields assembled little-endian into their output registers as bytes arrive.
- Checks, each evaluated on acceptance of the field's last byte: bytes 0-3 = "RIFF"; 8-11 = "WAVE"; 12-15 = "fmt "; 16-19 = 16; 20-21 = 1 (PCM); 36-39 = "data". When STRICT=1 also: 22-23 = 1, 34-35 = 8, 32-33 = 1. Bytes 4-7 and 28-31 captured internally only, not checked.
- Any failed check -> ERROR on the next cycle; remaining header bytes not consumed.
- Byte 43 accepted with no failure -> `hdr_done_o`=1; 32-bit remaining counter loaded with `data_size`; next state DATA, or DRAIN directly if `data_size`=0.
- DATA: single-entry output register. `byte_ready_o = ~sample_valid_o | sample_ready_i`. Accepted byte -> `sample_data_o`, `sample_valid_o`=1, remaining counter decrements. When the byte that brings the counter to 0 is accepted -> DRAIN.
- DRAIN: `byte_ready_o`=0; waits for final sample handshake (immediate if none pending) -> DONE.
- DONE: `done_o`=1, `byte_ready_o`=0, `sample_valid_o`=0. Trailing bytes after the data chunk are not consumed.
- ERROR: `error_o`=1, `byte_ready_o`=0, `sample_valid_o`=0, field outputs hold values captured so far.
- `restart_i` has priority over every handshake in the same cycle: the byte is not accepted, a pending sample is dropped (`sample_valid_o`->0), counters/fields/flags -> 0, state -> HEADER.

## Timing

- Reset values: `sample_valid_o`=0, `sample_data_o`=0, all field outputs 0, `hdr_done_o`=`done_o`=`error_o`=0; state HEADER so `byte_ready_o`=1 (combinational from state).
- Header acceptance: 1 byte/cycle; 44 cycles minimum for a back-to-back header.
- `hdr_done_o`/`error_o` rise the cycle after the deciding byte handshake.
- Payload latency: byte accepted at edge N -> `sample_valid_o`/`sample_data_o` valid after edge N; full throughput 1 sample/cycle with `sample_ready_i` held high.
- `sample_valid_o` and `sample_data_o` stable while `sample_valid_o & ~sample_ready_i`.
- `done_o` rises the cycle after the last sample handshake.
- Asynchronous reset mid-file: all state cleared immediately; partial file is discarded.

## Test plan

- Valid 8-bit mono 48000 Hz header, `data_size`=4, payload 0x80,0xFF,0x00,0x7F, sink always ready -> `sample_rate_o`=48000, `num_channels_o`=1, `bits_per_sample_o`=8, samples 0x80,0xFF,0x00,0x7F on 4 consecutive cycles, `done_o`=1 one cycle after the last; further bytes see `byte_ready_o`=0.
- Same file, `sample_ready_i` toggling 1/0 each cycle -> no sample lost or duplicated, `sample_data_o` stable while stalled, `byte_ready_o`=0 while the output register is full and stalled.
- Byte 8 = "X" instead of "W" -> `error_o`=1 the cycle after byte 11 is accepted, `hdr_done_o`=0, `byte_ready_o`=0; `restart_i` then a valid file -> parses normally.
- STRICT=1, `num_channels`=2 -> `error_o` after byte 23; STRICT=0, same header with block align 2 and 16 bits/sample -> `hdr_done_o`=1 and payload forwarded.
- `data_size`=0 -> `hdr_done_o` and DONE reached with no `sample_valid_o` pulse; `done_o`=1 two cycles after byte 43 is accepted.
- `restart_i` asserted with a pending stalled sample mid-payload -> `sample_valid_o`=0 and all fields 0 next cycle, byte on that cycle not accepted; async `rstn` low mid-header -> every output at its reset value immediately.
